// File: rtl/mandelbrot_iter_if.sv
// Pixel handshake bundle between the coordinate mapper, the escape-time engine
// and the frame RAM writer.
interface mandelbrot_iter_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8,
  parameter int XY_W  = 10
);
  logic                    in_valid;
  logic                    in_ready;
  logic signed [WIDTH-1:0] c_re;
  logic signed [WIDTH-1:0] c_im;
  logic [XY_W-1:0]         x_in;
  logic [XY_W-1:0]         y_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [CNT_W-1:0]        count_out;
  logic [XY_W-1:0]         x_out;
  logic [XY_W-1:0]         y_out;
  logic                    busy;

  modport master (
    output in_valid, c_re, c_im, x_in, y_in, out_ready,
    input  in_ready, out_valid, count_out, x_out, y_out, busy
  );

  modport slave (
    input  in_valid, c_re, c_im, x_in, y_in, out_ready,
    output in_ready, out_valid, count_out, x_out, y_out, busy
  );
endinterface

// File: rtl/mandelbrot_iter.sv
// Escape-time engine: iterates z <= z^2 + c in signed fixed point, one
// iteration per clock, and returns the iteration count with the pixel position.
module mandelbrot_iter #(
  parameter int WIDTH    = 32,
  parameter int FRAC     = 28,
  parameter int MAX_ITER = 255,
  parameter int CNT_W    = 8,
  parameter int XY_W     = 10
) (
  input  logic            clk,
  input  logic            rst,
  mandelbrot_iter_if.slave bus
);

  localparam int PW = 2 * WIDTH;
  localparam logic [CNT_W-1:0] N_MAX = CNT_W'(MAX_ITER);
  // 4.0 at the sum width; the sum is one bit wider than the products so it cannot wrap
  localparam logic signed [PW:0] MAG_LIMIT = {{(PW-FRAC-2){1'b0}}, 3'b100, {FRAC{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_next;

  logic signed [WIDTH-1:0] r_zr;
  logic signed [WIDTH-1:0] r_zi;
  logic signed [WIDTH-1:0] r_cre;
  logic signed [WIDTH-1:0] r_cim;
  logic [CNT_W-1:0]        r_n;
  logic [CNT_W-1:0]        r_count;
  logic [XY_W-1:0]         r_x;
  logic [XY_W-1:0]         r_y;
  logic                    r_in_ready;
  logic                    r_out_valid;
  logic                    r_busy;

  logic signed [PW-1:0] w_zr_ext;
  logic signed [PW-1:0] w_zi_ext;
  logic signed [PW-1:0] w_cre_ext;
  logic signed [PW-1:0] w_cim_ext;
  logic signed [PW-1:0] w_prod_rr;
  logic signed [PW-1:0] w_prod_ii;
  logic signed [PW-1:0] w_prod_ri;
  logic signed [PW-1:0] w_zr2;
  logic signed [PW-1:0] w_zi2;
  logic signed [PW-1:0] w_zri;
  logic signed [PW:0]   w_mag;
  logic signed [PW-1:0] w_zr_sum;
  logic signed [PW-1:0] w_zi_sum;
  logic                 w_unused_hi;

  logic             w_load;
  logic             w_step;
  logic             w_finish;
  logic [CNT_W-1:0] w_fin_cnt;

  // Full-width signed products, so the arithmetic shift sees every bit.
  assign w_zr_ext  = {{WIDTH{r_zr[WIDTH-1]}}, r_zr};
  assign w_zi_ext  = {{WIDTH{r_zi[WIDTH-1]}}, r_zi};
  assign w_cre_ext = {{WIDTH{r_cre[WIDTH-1]}}, r_cre};
  assign w_cim_ext = {{WIDTH{r_cim[WIDTH-1]}}, r_cim};
  assign w_prod_rr = w_zr_ext * w_zr_ext;
  assign w_prod_ii = w_zi_ext * w_zi_ext;
  assign w_prod_ri = w_zr_ext * w_zi_ext;
  assign w_zr2     = w_prod_rr >>> FRAC;
  assign w_zi2     = w_prod_ii >>> FRAC;
  assign w_zri     = w_prod_ri >>> FRAC;
  assign w_mag     = {w_zr2[PW-1], w_zr2} + {w_zi2[PW-1], w_zi2};
  assign w_zr_sum  = w_zr2 - w_zi2 + w_cre_ext;
  assign w_zi_sum  = (w_zri <<< 1) + w_cim_ext;
  // The z registers keep only the low WIDTH bits of each update.
  assign w_unused_hi = ^{w_zr_sum[PW-1:WIDTH], w_zi_sum[PW-1:WIDTH]};

  // Next-state and datapath control decode.
  always_comb begin
    w_next    = r_state;
    w_load    = 1'b0;
    w_step    = 1'b0;
    w_finish  = 1'b0;
    w_fin_cnt = r_n;
    case (r_state)
      S_IDLE: begin
        if (bus.in_valid && r_in_ready) begin
          w_next = S_ITER;
          w_load = 1'b1;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_ITER: begin
        if (w_mag > MAG_LIMIT) begin
          w_next    = S_DONE;
          w_finish  = 1'b1;
          w_fin_cnt = r_n;
        end else if (r_n == N_MAX) begin
          w_next    = S_DONE;
          w_finish  = 1'b1;
          w_fin_cnt = N_MAX;
        end else begin
          w_step = 1'b1;
        end
      end
      S_DONE: begin
        if (r_out_valid && bus.out_ready) begin
          w_next = S_IDLE;
        end else begin
          w_next = S_DONE;
        end
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register and registered handshake/status flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_next;
      r_in_ready  <= (w_next == S_IDLE);
      r_out_valid <= (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  // Iteration state: captured coordinate, z and the iteration counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cre <= '0;
      r_cim <= '0;
      r_zr  <= '0;
      r_zi  <= '0;
      r_n   <= '0;
    end else if (w_load) begin
      r_cre <= bus.c_re;
      r_cim <= bus.c_im;
      r_zr  <= '0;
      r_zi  <= '0;
      r_n   <= '0;
    end else if (w_step) begin
      r_zr <= w_zr_sum[WIDTH-1:0];
      r_zi <= w_zi_sum[WIDTH-1:0];
      r_n  <= r_n + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  // Result registers; position is taken at accept and held through DONE.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= '0;
      r_x     <= '0;
      r_y     <= '0;
    end else begin
      if (w_load) begin
        r_x <= bus.x_in;
        r_y <= bus.y_in;
      end
      if (w_finish) begin
        r_count <= w_fin_cnt;
      end
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.busy      = r_busy;
  assign bus.count_out = r_count;
  assign bus.x_out     = r_x;
  assign bus.y_out     = r_y;

endmodule

// File: tb/tb_mandelbrot_iter.sv
// Self-checking bench for mandelbrot_iter: table of known points, back-pressure,
// reset abort and a streaming run against a bit-exact reference model.
module tb_mandelbrot_iter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  mandelbrot_iter_if #(.WIDTH(32), .CNT_W(8), .XY_W(10)) bus ();

  mandelbrot_iter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic signed [31:0] cre;
    logic signed [31:0] cim;
    logic [9:0]         x;
    logic [9:0]         y;
    logic [7:0]         cnt;
    int                 hold;
  } vec_t;

  typedef struct {
    logic [7:0] cnt;
    logic [9:0] x;
    logic [9:0] y;
  } res_t;

  res_t sb_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [7:0] ref_count(input logic signed [31:0] cr, input logic signed [31:0] ci);
    logic signed [31:0] zr;
    logic signed [31:0] zi;
    longint a, b, p, mag;
    zr = 32'sd0;
    zi = 32'sd0;
    for (int n = 0; n <= 255; n++) begin
      a   = (longint'(zr) * longint'(zr)) >>> 28;
      b   = (longint'(zi) * longint'(zi)) >>> 28;
      p   = (longint'(zr) * longint'(zi)) >>> 28;
      mag = a + b;
      if (mag > 64'sd1073741824) return 8'(n);
      if (n == 255) return 8'd255;
      zr = 32'(a - b + longint'(cr));
      zi = 32'((p <<< 1) + longint'(ci));
    end
    return 8'd255;
  endfunction

  task automatic compare_out(input string tag);
    res_t e;
    if (sb_q.size() == 0) begin
      check({tag, "_unexpected_output"}, 64'd1, 64'd0);
    end else begin
      e = sb_q.pop_front();
      check({tag, "_count"}, 64'(bus.count_out), 64'(e.cnt));
      check({tag, "_x"}, 64'(bus.x_out), 64'(e.x));
      check({tag, "_y"}, 64'(bus.y_out), 64'(e.y));
    end
  endtask

  task automatic run_pixel(input vec_t v, input string tag);
    int   lat;
    bit   ok;
    bit   stable;
    res_t snap;
    @(negedge clk);
    bus.c_re = v.cre; bus.c_im = v.cim; bus.x_in = v.x; bus.y_in = v.y;
    bus.in_valid = 1'b1;
    lat = 0;
    while (!bus.in_ready && lat < 600) begin
      @(negedge clk);
      lat++;
    end
    check({tag, "_ready_seen"}, 64'(bus.in_ready), 64'd1);
    @(posedge clk);
    sb_q.push_back('{cnt: v.cnt, x: v.x, y: v.y});
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.c_re = 32'(int'($urandom)); bus.x_in = 10'h2AA; bus.y_in = 10'h155;
    check({tag, "_busy_after_accept"}, {63'd0, bus.busy}, 64'd1);
    check({tag, "_ready_low_after_accept"}, {63'd0, bus.in_ready}, 64'd0);
    lat = 0; ok = 1'b0;
    while (!ok && lat < 400) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
      if (bus.out_valid) ok = 1'b1;
    end
    check({tag, "_latency"}, 64'(lat), 64'(v.cnt) + 64'd1);
    compare_out(tag);
    snap = '{cnt: bus.count_out, x: bus.x_out, y: bus.y_out};
    stable = 1'b1;
    for (int i = 0; i < v.hold; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (!bus.out_valid || bus.in_ready || bus.count_out !== snap.cnt ||
          bus.x_out !== snap.x || bus.y_out !== snap.y) stable = 1'b0;
    end
    if (v.hold > 0) check({tag, "_backpressure_stable"}, {63'd0, stable}, 64'd1);
    bus.out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.out_ready = 1'b0;
    check({tag, "_valid_drop"}, {63'd0, bus.out_valid}, 64'd0);
    check({tag, "_ready_after_hs"}, {63'd0, bus.in_ready}, 64'd1);
    check({tag, "_busy_after_hs"}, {63'd0, bus.busy}, 64'd0);
  endtask

  vec_t vecs[8];
  logic signed [31:0] rnd_re[16];
  logic signed [31:0] rnd_im[16];
  logic [9:0]         rnd_x[16];
  logic [9:0]         rnd_y[16];

  initial begin
    int   acc, got, budget, quiet;
    bit   reload, seen, overlap;
    vecs[0] = '{cre: 32'sh0000_0000, cim: 32'sh0000_0000, x: 10'd5,    y: 10'd7,   cnt: 8'd255, hold: 0};
    vecs[1] = '{cre: 32'sh2000_0000, cim: 32'sh0000_0000, x: 10'd1,    y: 10'd2,   cnt: 8'd2,   hold: 0};
    vecs[2] = '{cre: 32'sh1000_0000, cim: 32'sh1000_0000, x: 10'd100,  y: 10'd200, cnt: 8'd2,   hold: 20};
    vecs[3] = '{cre: 32'sh0000_0000, cim: 32'sh0000_0000, x: 10'd1023, y: 10'd767, cnt: 8'd255, hold: 0};
    vecs[4] = '{cre: 32'sh0800_0000, cim: 32'sh0000_0000, x: 10'd3,    y: 10'd4,   cnt: 8'd5,   hold: 0};
    vecs[5] = '{cre: 32'shE000_0000, cim: 32'sh0000_0000, x: 10'd512,  y: 10'd0,   cnt: 8'd255, hold: 3};
    vecs[6] = '{cre: 32'sh0000_0000, cim: 32'sh2000_0000, x: 10'd0,    y: 10'd1,   cnt: 8'd2,   hold: 0};
    vecs[7] = '{cre: 32'shF000_0000, cim: 32'sh0000_0000, x: 10'd9,    y: 10'd10,  cnt: 8'd255, hold: 0};

    bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    bus.c_re = 32'sd0; bus.c_im = 32'sd0; bus.x_in = 10'd0; bus.y_in = 10'd0;
    #3;
    check("reset_in_ready", {63'd0, bus.in_ready}, 64'd0);
    check("reset_out_valid", {63'd0, bus.out_valid}, 64'd0);
    check("reset_busy", {63'd0, bus.busy}, 64'd0);
    check("reset_outputs", {44'd0, bus.count_out, bus.x_out, bus.y_out}, 64'd0);
    @(negedge clk);
    rst = 1'b1;
    check("ready_before_first_edge", {63'd0, bus.in_ready}, 64'd0);
    @(negedge clk);
    check("ready_after_first_edge", {63'd0, bus.in_ready}, 64'd1);

    for (int i = 0; i < 8; i++) run_pixel(vecs[i], $sformatf("vec%0d", i));

    // Reset in the middle of an iteration aborts the pixel without output.
    @(negedge clk);
    bus.c_re = 32'sd0; bus.c_im = 32'sd0; bus.x_in = 10'd11; bus.y_in = 10'd12;
    bus.in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    check("abort_accepted", {63'd0, bus.busy}, 64'd1);
    repeat (49) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("abort_valid_low", {63'd0, bus.out_valid}, 64'd0);
    check("abort_ready_low", {63'd0, bus.in_ready}, 64'd0);
    check("abort_busy_low", {63'd0, bus.busy}, 64'd0);
    check("abort_count_zero", 64'(bus.count_out), 64'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("abort_ready_after_release", {63'd0, bus.in_ready}, 64'd1);
    seen = 1'b0;
    for (quiet = 0; quiet < 300; quiet++) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1'b1;
    end
    check("abort_no_output", {63'd0, seen}, 64'd0);
    run_pixel('{cre: 32'sh1000_0000, cim: 32'sh1000_0000, x: 10'd77, y: 10'd88, cnt: 8'd2, hold: 0}, "post_abort");

    // Streaming with in_valid held high, checked against the reference model.
    for (int i = 0; i < 16; i++) begin
      rnd_re[i] = 32'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
      rnd_im[i] = 32'(int'($urandom_range(0, 32'h4000_0000)) - 32'sh2000_0000);
      rnd_x[i]  = 10'($urandom_range(0, 1023));
      rnd_y[i]  = 10'($urandom_range(0, 1023));
    end
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.c_re = rnd_re[0]; bus.c_im = rnd_im[0]; bus.x_in = rnd_x[0]; bus.y_in = rnd_y[0];
    bus.in_valid = 1'b1;
    acc = 0; got = 0; budget = 0; reload = 1'b0; overlap = 1'b0;
    while (got < 16 && budget < 8000) begin
      if (bus.in_ready && (bus.busy || bus.out_valid)) overlap = 1'b1;
      if (bus.out_valid) begin
        compare_out($sformatf("stream%0d", got));
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        sb_q.push_back('{cnt: ref_count(rnd_re[acc], rnd_im[acc]), x: rnd_x[acc], y: rnd_y[acc]});
        acc++;
        reload = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
      budget++;
      if (reload) begin
        reload = 1'b0;
        if (acc < 16) begin
          bus.c_re = rnd_re[acc]; bus.c_im = rnd_im[acc]; bus.x_in = rnd_x[acc]; bus.y_in = rnd_y[acc];
        end else begin
          bus.in_valid = 1'b0;
        end
      end
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    check("stream_outputs", 64'(got), 64'd16);
    check("stream_accepts", 64'(acc), 64'd16);
    check("stream_queue_empty", 64'(sb_q.size()), 64'd0);
    check("stream_ready_exclusive", {63'd0, overlap}, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
